// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, exponent constants
// and the divider state encoding.
package fpu_pkg;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int QW      = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } fdiv_state_t;

    function automatic logic [31:0] pack_fp(input logic s, input logic [EXP_W-1:0] e,
                                            input logic [MAN_W-1:0] m);
        return {s, e, m};
    endfunction
endpackage

// File: rtl/fdiv_step.sv
// One combinational restoring-division step: subtract when the partial
// remainder covers the divisor, then shift the remainder left.
module fdiv_step
    import fpu_pkg::*;
(
    input  logic [QW-1:0]  rem,
    input  logic [MAN_W:0] div,
    output logic [QW-1:0]  rem_next,
    output logic           qbit
);
    logic [QW-1:0] div_ext;
    logic [QW-1:0] diff;

    assign div_ext  = {{(QW-MAN_W-1){1'b0}}, div};
    assign diff     = rem - div_ext;
    assign qbit     = (rem >= div_ext);
    assign rem_next = (qbit ? diff : rem) << 1;
endmodule

// File: rtl/fdiv.sv
// Iterative single-precision divider y = x1 / x2, BITS_PER_CYCLE quotient bits
// per clock. Define FDIV_ROUND_EN for round-to-nearest-even instead of truncation.
module fdiv
    import fpu_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int NC = QW / BITS_PER_CYCLE;

    fdiv_state_t state, state_next;
    logic [4:0]        cnt;
    logic              sign;
    logic [EXP_W-1:0]  e1, e2;
    logic [QW-1:0]     rem;
    logic [MAN_W:0]    div;
    logic [QW-1:0]     q;

    logic [QW-1:0]             rem_chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] qbits;
    logic [QW-1:0]             q_next;

    assign rem_chain[0] = rem;

    // Earlier steps in the chain resolve the more significant quotient bits.
    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
        fdiv_step u_step (
            .rem      (rem_chain[i]),
            .div      (div),
            .rem_next (rem_chain[i+1]),
            .qbit     (qbits[BITS_PER_CYCLE-1-i])
        );
    end

    assign q_next   = {q[QW-1-BITS_PER_CYCLE:0], qbits};
    assign in_ready = (state == IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (cnt == 5'(NC-1)) state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    if (out_valid && out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic [MAN_W-1:0] ym, ym_r;
    logic [9:0]       ye, ye_r;
    logic [31:0]      y_norm;
    logic             ovf_norm;
`ifdef FDIV_ROUND_EN
    logic             guard, sticky, carry;
`endif

    always_comb begin
        ym = q[QW-1] ? q[QW-2:2] : q[QW-3:1];
        ye = {2'b00, e1} - {2'b00, e2} + 10'(BIAS) - {9'd0, ~q[QW-1]};
`ifdef FDIV_ROUND_EN
        guard  = q[QW-1] ? q[1] : q[0];
        sticky = (q[QW-1] & q[0]) | (|rem);
        {carry, ym_r} = {1'b0, ym} + 24'(guard & (sticky | ym[0]));
        ye_r = ye + {9'd0, carry};
`else
        ym_r = ym;
        ye_r = ye;
`endif
        ovf_norm = 1'b0;
        if (e2 == '0) begin
            y_norm   = pack_fp(sign, 8'(EXP_MAX), '0);
            ovf_norm = 1'b1;
        end else if (e1 == '0) begin
            y_norm = pack_fp(sign, '0, '0);
        end else if ($signed(ye_r) >= 10'sd255) begin
            y_norm   = pack_fp(sign, 8'(EXP_MAX), '0);
            ovf_norm = 1'b1;
        end else if ($signed(ye_r) <= 10'sd0) begin
            y_norm = pack_fp(sign, '0, '0);
        end else begin
            y_norm = pack_fp(sign, ye_r[7:0], ym_r);
        end
    end

    // y is loaded in NORM; out_valid follows one edge later in DONE.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            sign      <= 1'b0;
            e1        <= '0;
            e2        <= '0;
            rem       <= '0;
            div       <= '0;
            q         <= '0;
            y         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (in_valid) begin
                    sign <= x1[31] ^ x2[31];
                    e1   <= x1[30:23];
                    e2   <= x2[30:23];
                    rem  <= {2'b01, x1[22:0]};
                    div  <= {1'b1, x2[22:0]};
                    q    <= '0;
                    cnt  <= '0;
                end
                CALC: begin
                    rem <= rem_chain[BITS_PER_CYCLE];
                    q   <= q_next;
                    cnt <= cnt + 5'd1;
                end
                NORM: begin
                    y   <= y_norm;
                    ovf <= ovf_norm;
                end
                DONE: out_valid <= !(out_valid && out_ready);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fdiv.sv
// Self-checking bench for fdiv: directed cases plus random operands checked
// against an integer-arithmetic reference of the divide rules.
module tb_fdiv;
    localparam int BPC = 1;
    localparam int NC  = 26 / BPC;
    localparam int LAT = NC + 2;

    logic        clk, rstn;
    logic [31:0] x1, x2, y;
    logic        in_valid, in_ready, ovf, out_valid, out_ready;

    fdiv #(.BITS_PER_CYCLE(BPC)) dut (
        .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .in_valid(in_valid),
        .in_ready(in_ready), .y(y), .ovf(ovf), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, y} from the division rules using plain integer arithmetic.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic   s;
        int     e1, e2, ye;
        longint n, d, qq, r, ym;
        s  = a[31] ^ b[31];
        e1 = int'(a[30:23]);
        e2 = int'(b[30:23]);
        if (e2 == 0) return {1'b1, s, 8'hFF, 23'd0};
        if (e1 == 0) return {1'b0, s, 31'd0};
        n  = longint'({1'b1, a[22:0]}) << 25;
        d  = longint'({1'b1, b[22:0]});
        qq = n / d;
        r  = n % d;
        ye = e1 - e2 + 127;
        if (qq >= (longint'(1) << 25)) begin
            ym = (qq >> 2) & longint'(32'h7FFFFF);
`ifdef FDIV_ROUND_EN
            if (qq[1] && (qq[0] || r != 0 || ym[0])) ym++;
`endif
        end else begin
            ye = ye - 1;
            ym = (qq >> 1) & longint'(32'h7FFFFF);
`ifdef FDIV_ROUND_EN
            if (qq[0] && (r != 0 || ym[0])) ym++;
`endif
        end
        if (ym == longint'(32'h800000)) begin
            ym = 0;
            ye = ye + 1;
        end
        if (ye >= 255) return {1'b1, s, 8'hFF, 23'd0};
        if (ye <= 0)   return {1'b0, s, 31'd0};
        return {1'b0, s, 8'(ye), 23'(ym)};
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          input logic [31:0] exp_y, input logic exp_ovf, input string tag);
        int wait_n;
        @(negedge clk);
        x1 = a; x2 = b; in_valid = 1'b1; out_ready = 1'b0;
        wait_n = 0;
        while (!in_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0; x1 = $urandom; x2 = $urandom;
        wait_n = 0;
        while (!out_valid && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, " latency"}, 32'(wait_n), 32'(LAT));
        check({tag, " y"}, y, exp_y);
        check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            @(negedge clk);
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold y"}, y, exp_y);
            check({tag, " hold ovf"}, 32'(ovf), 32'(exp_ovf));
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " post out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_model(input logic [31:0] a, input logic [31:0] b, input int hold,
                             input string tag);
        logic [32:0] e;
        e = ref_div(a, b);
        run_op(a, b, hold, e[31:0], e[32], tag);
    endtask

    initial begin
        logic [31:0] a, b, third;
        int seen;
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x1 = '0; x2 = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        check("reset y", y, 32'h0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);

`ifdef FDIV_ROUND_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif
        run_op(32'h40C00000, 32'h40000000, 0, 32'h40400000, 1'b0, "six_by_two");
        run_op(32'h3F800000, 32'h40400000, 0, third,        1'b0, "one_third");
        run_op(32'hBF800000, 32'h00000000, 0, 32'hFF800000, 1'b1, "div_zero");
        run_op(32'h00000000, 32'h3F800000, 0, 32'h00000000, 1'b0, "zero_num");
        run_op(32'h7F000000, 32'h00800000, 0, 32'h7F800000, 1'b1, "overflow");
        run_op(32'h00800000, 32'h40000000, 0, 32'h00000000, 1'b0, "underflow");
        run_op(32'h40C00000, 32'h40000000, 5, 32'h40400000, 1'b0, "backpressure");

        // Reset in the middle of CALC must drop the operation entirely.
        @(negedge clk);
        x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset y", y, 32'h0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midreset no result", 32'(seen), 32'd0);
        run_op(32'h40C00000, 32'h40000000, 0, 32'h40400000, 1'b0, "after_reset");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) != 0) a[30:23] = 8'($urandom_range(60, 194));
            if ($urandom_range(0, 3) != 0) b[30:23] = 8'($urandom_range(60, 194));
            run_model(a, b, $urandom_range(0, 3), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
